// File: rtl/me_host_bridge.sv
// me_host_bridge
//   Host-side initiator for the modular-exponentiation core. Accepts one
//   K*N-bit operand pair, pulses me_start, streams both operands LSW-first
//   (N words plus one trailing all-zero beat), then gathers the N result
//   words the core returns and presents them as one K*N-bit value.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    operand-pair handshake (ready only in IDLE)
//   big_x, big_y             operands, captured on accept
//   me_start                 one-cycle start pulse to the core
//   me_x, me_y               operand words, me_x_valid == me_y_valid
//   me_result, me_valid      result word stream from the core
//   result, done             assembled result (word 0 in [K-1:0]) + pulse
//   timeout_err              sticky abort flag, cleared on next accept
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request
// START | me_start high for this cycle
// GAP   | START_GAP quiet cycles before the first operand beat
// SEND  | one operand beat per cycle, N data beats + one zero beat
// WAIT  | waiting for the first result word, bounded by TIMEOUT
// RECV  | collecting result words 1..N-1, stalls when me_valid is low
module me_host_bridge #(
  parameter int K         = 128,
  parameter int N         = 32,
  parameter int START_GAP = 10,
  parameter int TIMEOUT   = 2**20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [K*N-1:0] big_x,
  input  logic [K*N-1:0] big_y,
  output logic           me_start,
  output logic [K-1:0]   me_x,
  output logic [K-1:0]   me_y,
  output logic           me_x_valid,
  output logic           me_y_valid,
  input  logic [K-1:0]   me_result,
  input  logic           me_valid,
  output logic [K*N-1:0] result,
  output logic           done,
  output logic           timeout_err
);

  localparam int W  = K * N;
  localparam int CW = $clog2(N + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(START_GAP + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(N);
  localparam logic [CW-1:0] WORDS     = CW'(N);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE    = TW'(1);
  localparam logic [GW-1:0] GAP_INIT  = GW'(START_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_GAP, S_SEND, S_WAIT, S_RECV
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_sr_q, x_sr_d;
  logic [W-1:0]    y_sr_q, y_sr_d;
  logic [W-1:0]    res_sr_q, res_sr_d;
  logic [W-1:0]    result_q, result_d;
  logic [K-1:0]    me_x_q, me_x_d;
  logic [K-1:0]    me_y_q, me_y_d;
  logic            mv_q, mv_d;
  logic            start_q, start_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;
  logic            ready_q, ready_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [W-1:0]    cap_sr;
  logic [CW-1:0]   cnt_cap;

  // Incoming word enters at the top; after N captures word 0 is at the bottom.
  assign cap_sr = (res_sr_q >> K) | (W'(me_result) << (W - K));

  always_comb begin
    state_d  = state_q;
    x_sr_d   = x_sr_q;
    y_sr_d   = y_sr_q;
    res_sr_d = res_sr_q;
    result_d = result_q;
    me_x_d   = '0;
    me_y_d   = '0;
    mv_d     = 1'b0;
    start_d  = 1'b0;
    done_d   = 1'b0;
    terr_d   = terr_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    gap_d    = gap_q;
    cnt_cap  = cnt_q + CNT_ONE;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          x_sr_d  = big_x;
          y_sr_d  = big_y;
          terr_d  = 1'b0;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        gap_d   = GAP_INIT;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) begin
          // Beat 0 is registered on the edge that leaves GAP.
          mv_d    = 1'b1;
          me_x_d  = x_sr_q[K-1:0];
          me_y_d  = y_sr_q[K-1:0];
          x_sr_d  = x_sr_q >> K;
          y_sr_d  = y_sr_q >> K;
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      S_SEND: begin
        // cnt_q is the index of the beat on the bus this cycle. The shift
        // registers are empty by beat N, so the trailing beat is zero.
        if (cnt_q == BEAT_LAST) begin
          to_d    = '0;
          state_d = S_WAIT;
        end else begin
          mv_d   = 1'b1;
          me_x_d = x_sr_q[K-1:0];
          me_y_d = y_sr_q[K-1:0];
          x_sr_d = x_sr_q >> K;
          y_sr_d = y_sr_q >> K;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_WAIT, S_RECV: begin
        if (me_valid) begin
          cnt_cap  = (state_q == S_WAIT) ? CNT_ONE : (cnt_q + CNT_ONE);
          res_sr_d = cap_sr;
          cnt_d    = cnt_cap;
          if (cnt_cap == WORDS) begin
            result_d = cap_sr;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_RECV;
          end
        end else if (state_q == S_WAIT) begin
          if (to_q == TO_LAST) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            to_d = to_q + TO_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_sr_q   <= '0;
      y_sr_q   <= '0;
      res_sr_q <= '0;
      result_q <= '0;
      me_x_q   <= '0;
      me_y_q   <= '0;
      mv_q     <= 1'b0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
      to_q     <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_sr_q   <= x_sr_d;
      y_sr_q   <= y_sr_d;
      res_sr_q <= res_sr_d;
      result_q <= result_d;
      me_x_q   <= me_x_d;
      me_y_q   <= me_y_d;
      mv_q     <= mv_d;
      start_q  <= start_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      gap_q    <= gap_d;
    end
  end

  assign req_ready   = ready_q;
  assign me_start    = start_q;
  assign me_x        = me_x_q;
  assign me_y        = me_y_q;
  assign me_x_valid  = mv_q;
  assign me_y_valid  = mv_q;
  assign result      = result_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_me_host_bridge.sv
// Bench for me_host_bridge at K=8, N=4, START_GAP=2, TIMEOUT=50.
// A behavioural core model consumes operand beats and returns a result
// word stream with random latency, stalls and pre-WAIT noise pulses.
// Expected beats and results are queued at issue time and checked by a
// separate monitor.
module tb_me_host_bridge;

  localparam int K   = 8;
  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TO  = 50;
  localparam int W   = K * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] big_x = '0;
  logic [W-1:0] big_y = '0;
  logic         me_start;
  logic [K-1:0] me_x, me_y;
  logic         me_x_valid, me_y_valid;
  logic [K-1:0] me_result = '0;
  logic         me_valid = 1'b0;
  logic [W-1:0] result;
  logic         done;
  logic         timeout_err;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit abort_run = 0;

  me_host_bridge #(.K(K), .N(N), .START_GAP(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .big_x(big_x), .big_y(big_y),
    .me_start(me_start),
    .me_x(me_x), .me_y(me_y),
    .me_x_valid(me_x_valid), .me_y_valid(me_y_valid),
    .me_result(me_result), .me_valid(me_valid),
    .result(result), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    int           start_cyc;
    bit           no_resp;
  } exp_t;

  typedef struct {
    logic [W-1:0] r;
    bit           no_resp;
    int           lat;
    int           stall_mode;
    bit           noise;
  } core_t;

  exp_t  exp_q[$];
  core_t core_q[$];
  int    core_first_cyc, core_last_cyc, core_stalls;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [K-1:0] word_of(input logic [W-1:0] v, input int i);
    logic [W-1:0] s;
    if (i >= N) return '0;
    s = v >> (K * i);
    return s[K-1:0];
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t         cur;
    bit           active;
    bit           prev_terr;
    int           beat_idx, beatn_cyc;
    logic [W-1:0] last_res;
    active = 0; prev_terr = 0; beat_idx = 0; beatn_cyc = 0; last_res = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        active   = 0;
        last_res = '0;
      end else begin
        if (me_start) begin
          chk("start_ready_low", req_ready, 0);
          chk("start_terr_cleared", timeout_err, 0);
          chk("result_held", result, last_res);
          if (exp_q.size() == 0) chk("unexpected_start", me_start, 0);
          else begin
            cur = exp_q.pop_front();
            active = 1;
            beat_idx = 0;
            chk("start_cycle", cyc, cur.start_cyc);
          end
        end
        if (me_x_valid || me_y_valid) begin
          chk("valid_pair", me_y_valid, me_x_valid);
          if (!active) chk("beat_without_txn", me_x_valid, 0);
          else if (beat_idx > N) begin
            chk("extra_beat", beat_idx, N);
            beat_idx++;
          end else begin
            chk($sformatf("beat%0d_x", beat_idx), me_x, word_of(cur.x, beat_idx));
            chk($sformatf("beat%0d_y", beat_idx), me_y, word_of(cur.y, beat_idx));
            chk("beat_cycle", cyc, cur.start_cyc + 1 + GAP + beat_idx);
            if (beat_idx == N) beatn_cyc = cyc;
            beat_idx++;
          end
        end else begin
          chk("idle_bus_zero", {me_x, me_y}, 0);
        end
        if (done) begin
          if (!active) chk("spurious_done", done, 0);
          else begin
            chk("result", result, cur.r);
            chk("done_after_last_word", cyc, core_last_cyc + 1);
            chk("done_latency", cyc, core_first_cyc + N + core_stalls);
            chk("done_terr", timeout_err, 0);
            chk("done_on_timeout_txn", cur.no_resp, 0);
            chk("beat_count", beat_idx, N + 1);
            last_res = cur.r;
            active = 0;
          end
        end
        if (timeout_err && !prev_terr) begin
          if (!active) chk("spurious_timeout", timeout_err, 0);
          else begin
            chk("timeout_cycle", cyc, beatn_cyc + 1 + TO);
            chk("timeout_expected", cur.no_resp, 1);
            chk("timeout_ready", req_ready, 1);
            chk("beat_count", beat_idx, N + 1);
            active = 0;
          end
        end
      end
      prev_terr = timeout_err;
    end
  end

  // Behavioural core: counts operand beats, then streams the result back.
  initial begin : core
    core_t c;
    int    phase, nb, lat, widx, stall_left;
    phase = 0; nb = 0; lat = 0; widx = 0; stall_left = 0;
    forever begin
      @(posedge clk); #1;
      me_valid = 1'b0;
      if (rst) phase = 0;
      else begin
        case (phase)
          0: if (me_start && core_q.size() != 0) begin
               c = core_q.pop_front();
               nb = 0;
               phase = 1;
             end
          1: begin
               if (me_x_valid) nb++;
               if (nb == N + 1) begin
                 if (c.no_resp) phase = 0;
                 else begin
                   phase = 2;
                   lat = c.lat;
                 end
               end else if (c.noise && $urandom_range(3) == 0) begin
                 me_valid  = 1'b1;
                 me_result = K'($urandom);
               end
             end
          2: begin
               if (lat == 0) begin
                 phase = 3;
                 widx = 0;
                 stall_left = 0;
                 core_stalls = 0;
               end else lat--;
             end
          3: begin
               if (stall_left > 0) begin
                 stall_left--;
                 core_stalls++;
               end else if (c.stall_mode == 2 && widx > 0 && $urandom_range(2) == 0) begin
                 core_stalls++;
               end else begin
                 me_valid  = 1'b1;
                 me_result = word_of(c.r, widx);
                 if (widx == 0) core_first_cyc = cyc;
                 core_last_cyc = cyc;
                 widx++;
                 if (c.stall_mode == 1 && widx == 2) stall_left = 3;
                 if (widx == N) phase = 0;
               end
             end
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 3000) begin
      step();
      n++;
    end
    if (!req_ready) begin
      chk("ready_wait_bound", req_ready, 1);
      abort_run = 1;
    end
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r,
                       input bit no_resp, input int lat, input int smode, input bit noise,
                       output int acc);
    exp_t  e;
    core_t c;
    acc = 0;
    wait_ready();
    if (abort_run) return;
    e.x = x; e.y = y; e.r = r; e.start_cyc = cyc + 1; e.no_resp = no_resp;
    c.r = r; c.no_resp = no_resp; c.lat = lat; c.stall_mode = smode; c.noise = noise;
    exp_q.push_back(e);
    core_q.push_back(c);
    big_x = x;
    big_y = y;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    big_x = W'($urandom);
    big_y = W'($urandom);
    acc = cyc;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int           acc;
    logic [W-1:0] x, y;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ready", req_ready, 1);
    chk("rst_start", me_start, 0);
    chk("rst_valids", {me_x_valid, me_y_valid}, 0);
    chk("rst_bus", {me_x, me_y}, 0);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    step();

    // Reset in the middle of SEND (beat 3).
    issue(32'hA5A55A5A, 32'h0F0F1234, 32'h0, 0, 0, 0, 0, acc);
    repeat (4 + GAP) step();
    chk("pre_reset_in_send", me_x_valid, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valids", {me_x_valid, me_y_valid}, 0);
    chk("mid_rst_bus", {me_x, me_y}, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    repeat (3) step();

    // Directed operands and result, then the same with a 3-cycle stall.
    issue(32'h44332211, 32'hDDCCBBAA, 32'h04030201, 0, 2, 0, 0, acc);
    issue(32'h44332211, 32'hDDCCBBAA, 32'h04030201, 0, 1, 1, 1, acc);

    // Core never answers.
    issue(32'h12345678, 32'h9ABCDEF0, 32'h0, 1, 0, 0, 1, acc);
    wait_ready();
    step();
    chk("timeout_sticky", timeout_err, 1);

    for (int i = 0; i < 24 && !abort_run; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      issue(x, y, x * y + 32'h9E3779B9, ($urandom_range(7) == 0), $urandom_range(8),
            $urandom_range(2), $urandom_range(1), acc);
    end

    if (!abort_run) wait_ready();
    repeat (5) step();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("core_q_drained", core_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
